// File: rtl/op_issuer_pkg.sv
// Shared definitions for the op_issuer front-end and the matrix controller decode:
// opcode constants, issuer state encoding and command-word field positions.
package op_issuer_pkg;

   localparam logic [3:0] OP_IDLE = 4'd0;
   localparam logic [3:0] OP_MUL  = 4'd1;
   localparam logic [3:0] OP_LOAD = 4'd2;

   // Command word layout: [3:0] opcode, [15:4] operands, [31:16] length/cycle count
   localparam int OP_LSB  = 0;
   localparam int OP_MSB  = 3;
   localparam int ARG_LSB = 4;
   localparam int ARG_MSB = 15;
   localparam int LEN_LSB = 16;
   localparam int LEN_MSB = 31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MUL,
      ST_GAP
   } state_e;

   function automatic logic [3:0] cmd_op(input logic [31:0] word);
      return word[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [15:0] cmd_len(input logic [31:0] word);
      return word[LEN_MSB:LEN_LSB];
   endfunction

endpackage

// File: rtl/op_issuer_if.sv
// Host command/data handshakes plus the controller-facing drive signals of op_issuer.
interface op_issuer_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_data;
   logic        data_valid;
   logic        data_ready;
   logic [31:0] data_in;
   logic        enable;
   logic [31:0] operation;
   logic [31:0] in_data;
   logic        busy;
   logic        done;
   logic        err;

   modport slave (
      input  cmd_valid, cmd_data, data_valid, data_in,
      output cmd_ready, data_ready, enable, operation, in_data, busy, done, err
   );

   modport master (
      output cmd_valid, cmd_data, data_valid, data_in,
      input  cmd_ready, data_ready, enable, operation, in_data, busy, done, err
   );

endinterface

// File: rtl/op_len_counter.sv
// Loadable down-counter shared by the LOAD, MUL and GAP phases; last_o flags a count of one.
module op_len_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/op_issuer.sv
// Command front-end for the matrix controller: holds each opcode for its cycle/beat count,
// then forces an idle gap so consecutive matmuls present a fresh rising edge of opcode 1.
module op_issuer
   import op_issuer_pkg::*;
#(
   parameter int MUL_CYCLES = 80,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic        clk,
   input  logic        reset,
   op_issuer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [15:0]      word_q, word_d;
   logic             err_q, err_d;
   logic             rdy_q;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_dec;
   logic             cnt_last;
   logic [3:0]       op;
   logic [15:0]      len;

   assign op  = cmd_op(bus.cmd_data);
   assign len = cmd_len(bus.cmd_data);

   op_len_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .last_o     (cnt_last)
   );

   // NOTE: every output and next-state variable gets a default first so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      word_d         = word_q;
      err_d          = err_q;
      cnt_load       = 1'b0;
      cnt_val        = '0;
      cnt_dec        = 1'b0;
      bus.cmd_ready  = 1'b0;
      bus.data_ready = 1'b0;
      bus.enable     = 1'b1;
      bus.operation  = '0;
      bus.in_data    = '0;
      bus.done       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            bus.cmd_ready = rdy_q;
            if (rdy_q && bus.cmd_valid) begin
               word_d   = bus.cmd_data[ARG_MSB:OP_LSB];
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(GAP_CYCLES);
               state_d  = ST_GAP;
               if (op == OP_MUL) begin
                  cnt_val = (len != '0) ? CNT_W'(len) : CNT_W'(MUL_CYCLES);
                  state_d = ST_MUL;
               end else if (op == OP_LOAD && len != '0) begin
                  cnt_val = CNT_W'(len);
                  state_d = ST_LOAD;
               end else if (op != OP_IDLE) begin
                  // Unknown opcode or zero-length load: flag and retire through the gap.
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            bus.operation  = {16'h0, word_q};
            bus.data_ready = 1'b1;
            bus.enable     = bus.data_valid;
            bus.in_data    = bus.data_in;
            cnt_dec        = bus.data_valid;
            if (bus.data_valid && cnt_last) begin
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(GAP_CYCLES);
               state_d  = ST_GAP;
            end
         end
         ST_MUL: begin
            bus.operation = {16'h0, word_q};
            cnt_dec       = 1'b1;
            if (cnt_last) begin
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(GAP_CYCLES);
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               bus.done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         err_q   <= err_d;
         rdy_q   <= 1'b1;
      end
   end

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.err  = err_q;

endmodule

// File: tb/tb_op_issuer.sv
// Directed self-checking bench for op_issuer: reset, matmul hold, default hold, stalled load,
// back-to-back matmuls, illegal commands and asynchronous abort.
module tb_op_issuer;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   op_issuer_if bus ();

   op_issuer #(.MUL_CYCLES(80), .GAP_CYCLES(1), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here, away from the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [31:0] word);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = word;
      #1;
      check("send_ready", 32'(bus.cmd_ready), 32'd1);
      cyc();
      bus.cmd_valid = 1'b0;
      #1;
   endtask

   initial begin : stim
      logic [31:0] ld_data [4];
      logic        ld_vld  [6];
      int          n;
      int          writes;
      int          dones;
      logic [3:0]  b2b_exp [9];

      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_data   = '0;
      bus.data_valid = 1'b0;
      bus.data_in    = '0;

      // Reset state
      #3;
      check("rst_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_enable", 32'(bus.enable), 32'd1);
      check("rst_op", bus.operation, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      check("rel_ready_early", 32'(bus.cmd_ready), 32'd0);
      cyc();
      check("rel_ready", 32'(bus.cmd_ready), 32'd1);

      // Matmul len=5: opcode held 5 cycles, then one gap cycle with done
      send(32'h0005_3281);
      for (int i = 0; i < 5; i++) begin
         check("mm_op", bus.operation, 32'h0000_3281);
         check("mm_busy", 32'(bus.busy), 32'd1);
         cyc();
         #1;
      end
      check("mm_gap_op", bus.operation, 32'd0);
      check("mm_gap_done", 32'(bus.done), 32'd1);
      check("mm_gap_ready", 32'(bus.cmd_ready), 32'd0);
      cyc();
      check("mm_idle_ready", 32'(bus.cmd_ready), 32'd1);
      check("mm_idle_done", 32'(bus.done), 32'd0);

      // Default hold: len=0 means 80 cycles
      send(32'h0000_0201);
      n = 0;
      while (bus.operation[3:0] == 4'd1 && n < 200) begin
         n++;
         cyc();
         #1;
      end
      check("def_hold_cycles", 32'(n), 32'd80);
      check("def_gap_op", bus.operation, 32'd0);
      check("def_gap_done", 32'(bus.done), 32'd1);
      cyc();

      // Load 4 words with stalls
      ld_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
      ld_vld  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      send(32'h0004_0082);
      writes = 0;
      for (int i = 0; i < 6; i++) begin
         bus.data_valid = ld_vld[i];
         bus.data_in    = ld_vld[i] ? ld_data[writes] : 32'hDEAD_BEEF;
         #1;
         check("ld_enable", 32'(bus.enable), 32'(ld_vld[i]));
         check("ld_ready", 32'(bus.data_ready), 32'd1);
         check("ld_op", bus.operation, 32'h0000_0082);
         if (bus.enable) begin
            check("ld_in_data", bus.in_data, ld_data[writes]);
            writes++;
         end
         cyc();
      end
      bus.data_valid = 1'b1;
      #1;
      check("ld_writes", 32'(writes), 32'd4);
      check("ld_gap_op", bus.operation, 32'd0);
      check("ld_gap_done", 32'(bus.done), 32'd1);
      check("ld_gap_dready", 32'(bus.data_ready), 32'd0);
      check("ld_gap_enable", 32'(bus.enable), 32'd1);
      cyc();
      bus.data_valid = 1'b0;

      // Back-to-back matmuls with cmd_valid held high
      b2b_exp = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 32'h0003_3281;
      dones = 0;
      for (int i = 0; i < 9; i++) begin
         cyc();
         if (i == 5) bus.cmd_valid = 1'b0;
         #1;
         check("b2b_op", 32'(bus.operation[3:0]), 32'(b2b_exp[i]));
         if (bus.done) dones++;
      end
      check("b2b_dones", 32'(dones), 32'd2);
      cyc();

      // Illegal opcode then zero-length load: sticky err, gap + done each, enable stays high
      send(32'h0000_0007);
      check("ill_done", 32'(bus.done), 32'd1);
      check("ill_err", 32'(bus.err), 32'd1);
      check("ill_enable", 32'(bus.enable), 32'd1);
      check("ill_op", bus.operation, 32'd0);
      cyc();
      check("ill_err_sticky", 32'(bus.err), 32'd1);
      send(32'h0000_0082);
      check("zl_done", 32'(bus.done), 32'd1);
      check("zl_err", 32'(bus.err), 32'd1);
      check("zl_enable", 32'(bus.enable), 32'd1);
      cyc();
      check("zl_idle_err", 32'(bus.err), 32'd1);

      // Asynchronous reset in the middle of a long matmul
      send(32'h0014_3281);
      for (int i = 0; i < 10; i++) cyc();
      #1;
      check("abort_pre_op", bus.operation, 32'h0000_3281);
      reset = 1'b0;
      #1;
      check("abort_op", bus.operation, 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_err", 32'(bus.err), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      cyc();
      check("abort_hold_done", 32'(bus.done), 32'd0);
      reset = 1'b1;
      #1;
      check("abort_rel_ready", 32'(bus.cmd_ready), 32'd0);
      cyc();
      check("abort_ready", 32'(bus.cmd_ready), 32'd1);
      check("abort_post_done", 32'(bus.done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/op_issuer.md
Name: op_issuer

Overview:
- Command front-end that sits directly upstream of the matrix controller.
- Accepts 32-bit operation words and serial data words from the host over valid/ready handshakes.
- Drives the controller's `enable`, `operation` and `in_data` inputs: holds each opcode for exactly the number of cycles it needs, then inserts an idle gap so that every matmul presents a fresh rising edge of opcode 1.

Parameters:
- MUL_CYCLES, 80: default hold time in cycles for opcode 1 (2 X rows x 32 W cells, plus multiplier drain).
- GAP_CYCLES, 1: cycles with operation==0 after each command; minimum 1.
- CNT_W, 16: width of the length/cycle counter; equals the width of cmd_data[31:16].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- cmd_valid  in  1  host command word valid
- cmd_ready  out  1  issuer can accept a command (high only in IDLE)
- cmd_data  in  32  [15:0] operation fields as decoded by the controller; [31:16] length or cycle count
- data_valid  in  1  host serial data word valid
- data_ready  out  1  issuer consumes a data word this cycle
- data_in  in  32  serial data word
- enable  out  1  global enable to the controller
- operation  out  32  operation word to the controller
- in_data  out  32  data word to the controller
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command fully completes, including its gap
- err  out  1  sticky illegal-opcode / zero-length flag; cleared only by reset

Behaviour:
- Reset values while reset==0: state=IDLE, operation=0, in_data=0, enable=1, cmd_ready=0, data_ready=0, busy=0, done=0, err=0, counters=0. cmd_ready rises one cycle after reset deasserts.
- States are IDLE, LOAD, MUL, GAP.
- IDLE:
  - operation=0, enable=1, cmd_ready=1.
  - On cmd_valid, latch cmd_data and decode op=cmd_data[3:0], len=cmd_data[31:16].
  - op==1: go to MUL. Hold count = len if len!=0, else MUL_CYCLES.
  - op==2 with len!=0: go to LOAD. Remaining words = len.
  - op==2 with len==0: set err, go to GAP.
  - op==0: consumed as a no-op, go to GAP.
  - op 3..15: set err, go to GAP.
- LOAD:
  - operation = latched word with bits [31:16] forced to 0. data_ready=1.
  - enable = data_valid, so the controller writes exactly one word per accepted beat and freezes otherwise.
  - in_data = data_in combinationally, valid whenever enable=1.
  - Each data_valid beat decrements the remaining count. On the beat that takes it from 1 to 0, go to GAP.
  - Stall cycles (data_valid=0) do not count.
- MUL:
  - operation = latched word with bits [31:16] forced to 0. enable=1. data_ready=0.
  - Down-counter decrements every cycle. After exactly the hold count cycles with opcode 1 presented, go to GAP.
  - Example: len=5 means operation[3:0]==1 for exactly 5 consecutive cycles.
- GAP:
  - operation=0, enable=1.
  - Counts GAP_CYCLES cycles. On the last one, done=1 and the next state is IDLE.
  - This guarantees opcode 1 falls to 0 for at least one cycle between back-to-back matmuls, so the controller sees a new rising edge.
- Command latency: a command accepted in cycle T presents its opcode on `operation` in cycle T+1 (registered).
- Back-to-back commands: the minimum issue interval is len + GAP_CYCLES + 1 cycles (the extra cycle is IDLE).
- The counter is CNT_W bits wide. A len of 0xFFFF is legal and runs 65535 beats or cycles; there is no wrap.
- Asynchronous reset mid-command aborts immediately, with no done pulse. Partial page writes are left in memory.
- data_valid outside LOAD is ignored; data_ready stays 0.
- cmd_valid while not in IDLE is not accepted, because cmd_ready=0.

Decomposition:
- Shared package holds:
  - opcode constants OP_IDLE=0, OP_MUL=1, OP_LOAD=2;
  - state encoding IDLE/LOAD/MUL/GAP;
  - field slice positions for opcode, operands and length.
- The controller decode should import the same opcode constants.
- One natural sub-module: `op_len_counter`, a loadable down-counter with decrement enable and an is-last flag, reused by LOAD, MUL and GAP.

Test Plan:
- Reset: drive reset=0 mid-MUL at cycle 10 -> operation=0, busy=0 and err=0 in the same cycle; cmd_ready=1 one cycle after release; no done pulse.
- Matmul: cmd_data=0x0005_3281 -> operation=0x00003281 for exactly 5 cycles, then 0 for 1 cycle; done pulses on that gap cycle; cmd_ready returns the next cycle.
- Default hold: cmd_data=0x0000_0201 -> opcode 1 held for exactly 80 cycles.
- Load with stalls: cmd_data=0x0004_0082; data_valid pattern 1,0,1,1,0,1 with data_in=A,-,B,C,-,D -> enable=1,0,1,1,0,1; in_data=A,B,C,D on the enabled cycles; exactly 4 writes; then GAP, then done.
- Back-to-back matmuls: two 0x0003_3281 commands with cmd_valid held high -> opcode sequence 1,1,1,0,0,1,1,1,0 (gap then IDLE between commands); two done pulses.
- Illegal commands: cmd_data=0x0000_0007, then 0x0000_0082 (len=0) -> err=1 sticky; enable never drops; each command takes 1 gap cycle and produces done.
